// File: rtl/top_chip_intr_aggregator.sv
// Interrupt gateway and aggregator.
// Each source has a level/edge gateway feeding pending, active and missed
// flops. The lowest pending-and-enabled ID is presented on a registered
// irq_o/irq_id_o pair. The core takes that ID with a claim and retires it
// with a complete.
//
// Handshake: claim_i is a one-cycle strobe. Every cycle it is high counts
// as one claim. The result appears one cycle later as a one-cycle
// claim_valid_o pulse. claim_id_o holds the claimed ID, or 0 if nothing
// could be claimed, until the next claim. complete_i is a one-cycle strobe
// and carries complete_id_i. It is dropped silently unless the ID names a
// source that is currently active.
module top_chip_intr_aggregator #(
    parameter int NumSrc  = 46,
    parameter int IdWidth = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NumSrc-1:0]  intr_src_i,
    input  logic [NumSrc-1:0]  edge_mode_i,
    input  logic [NumSrc-1:0]  enable_i,
    input  logic               claim_i,
    input  logic               complete_i,
    input  logic [IdWidth-1:0] complete_id_i,
    output logic               irq_o,
    output logic [IdWidth-1:0] irq_id_o,
    output logic               claim_valid_o,
    output logic [IdWidth-1:0] claim_id_o,
    output logic [NumSrc-1:0]  pending_o,
    output logic [NumSrc-1:0]  active_o
);

    // The ID fields must be able to encode every source plus the "none" value 0.
    if (IdWidth < $clog2(NumSrc + 1)) begin : g_bad_id_width
        $error("IdWidth too small for NumSrc");
    end

    logic [NumSrc-1:0]  r_pending;
    logic [NumSrc-1:0]  r_active;
    logic [NumSrc-1:0]  r_missed;
    logic [NumSrc-1:0]  r_src_q;
    logic               r_irq;
    logic [IdWidth-1:0] r_irq_id;
    logic               r_claim_valid;
    logic [IdWidth-1:0] r_claim_id;

    logic [NumSrc-1:0]  w_cand;
    logic [IdWidth-1:0] w_win_id;
    logic [NumSrc-1:0]  w_claim_mask;
    logic [NumSrc-1:0]  w_cpl_mask;
    logic [NumSrc-1:0]  w_rise;
    logic [NumSrc-1:0]  w_trig;
    logic [NumSrc-1:0]  w_idle;
    logic [NumSrc-1:0]  w_release;
    logic [NumSrc-1:0]  w_edge_hit;
    logic [NumSrc-1:0]  w_pend_n;
    logic [NumSrc-1:0]  w_act_n;
    logic [NumSrc-1:0]  w_miss_n;

    assign w_cand = r_pending & enable_i;

    // Fixed-priority pick: scan from the top down so the lowest ID overwrites last.
    always_comb begin
        w_win_id = '0;
        for (int i = NumSrc - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win_id = IdWidth'(i + 1);
            end
        end
    end

    // Decode claim and complete into one-hot source masks. IDs 0 and
    // out-of-range values match no source, so invalid completes fall out.
    always_comb begin
        w_claim_mask = '0;
        w_cpl_mask   = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (claim_i && (w_win_id == IdWidth'(i + 1))) begin
                w_claim_mask[i] = 1'b1;
            end
            if (complete_i && (complete_id_i == IdWidth'(i + 1)) && r_active[i]) begin
                w_cpl_mask[i] = 1'b1;
            end
        end
    end

    // Gateway: an edge source triggers on a rise, a level source on a high level.
    assign w_rise     = intr_src_i & ~r_src_q;
    assign w_trig     = (edge_mode_i & w_rise) | (~edge_mode_i & intr_src_i);
    assign w_idle     = ~r_pending & ~r_active;
    // A missed edge left behind on an idle source is turned into a pending
    // request. This happens when an edge coincides with its own completion.
    assign w_release  = r_missed & w_idle;
    assign w_edge_hit = edge_mode_i & w_rise & ~w_idle;

    assign w_pend_n = (r_pending & ~w_claim_mask) | (w_trig & w_idle)
                    | (w_cpl_mask & r_missed) | w_release;
    assign w_act_n  = (r_active & ~w_cpl_mask) | w_claim_mask;
    // An edge in the same cycle that a missed edge is replayed by a completion
    // is merged into that replay, so it does not leave a second missed edge behind.
    assign w_miss_n = (r_missed & ~w_cpl_mask & ~w_release)
                    | (w_edge_hit & ~(w_cpl_mask & r_missed));

    // Per-source state flops and source history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pending <= '0;
            r_active  <= '0;
            r_missed  <= '0;
            r_src_q   <= '0;
        end else begin
            r_pending <= w_pend_n;
            r_active  <= w_act_n;
            r_missed  <= w_miss_n;
            r_src_q   <= intr_src_i;
        end
    end

    // Registered core-facing request and claim response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_irq         <= 1'b0;
            r_irq_id      <= '0;
            r_claim_valid <= 1'b0;
            r_claim_id    <= '0;
        end else begin
            r_irq         <= |w_cand;
            r_irq_id      <= w_win_id;
            r_claim_valid <= claim_i;
            if (claim_i) begin
                r_claim_id <= w_win_id;
            end
        end
    end

    assign irq_o         = r_irq;
    assign irq_id_o      = r_irq_id;
    assign claim_valid_o = r_claim_valid;
    assign claim_id_o    = r_claim_id;
    assign pending_o     = r_pending;
    assign active_o      = r_active;

endmodule

// File: tb/tb_top_chip_intr_aggregator.sv
module tb_top_chip_intr_aggregator;

    localparam int NumSrc  = 46;
    localparam int IdWidth = 6;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NumSrc-1:0]  intr_src = '0;
    logic [NumSrc-1:0]  edge_mode = '0;
    logic [NumSrc-1:0]  enable = '1;
    logic               claim = 1'b0;
    logic               complete = 1'b0;
    logic [IdWidth-1:0] complete_id = '0;
    logic               irq_o;
    logic [IdWidth-1:0] irq_id_o;
    logic               claim_valid_o;
    logic [IdWidth-1:0] claim_id_o;
    logic [NumSrc-1:0]  pending_o;
    logic [NumSrc-1:0]  active_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [NumSrc-1:0]  m_pend = '0;
    logic [NumSrc-1:0]  m_act = '0;
    logic [NumSrc-1:0]  m_miss = '0;
    logic [NumSrc-1:0]  m_srcq = '0;
    logic               m_irq = 1'b0;
    logic [IdWidth-1:0] m_irq_id = '0;
    logic               m_cv = 1'b0;
    logic [IdWidth-1:0] m_cid = '0;
    logic [IdWidth-1:0] exp_q[$];

    top_chip_intr_aggregator #(.NumSrc(NumSrc), .IdWidth(IdWidth)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .intr_src_i(intr_src),
        .edge_mode_i(edge_mode),
        .enable_i(enable),
        .claim_i(claim),
        .complete_i(complete),
        .complete_id_i(complete_id),
        .irq_o(irq_o),
        .irq_id_o(irq_id_o),
        .claim_valid_o(claim_valid_o),
        .claim_id_o(claim_id_o),
        .pending_o(pending_o),
        .active_o(active_o)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lowest enabled pending ID from the model, 0 if none
    function automatic int lowest_id();
        for (int k = 1; k <= NumSrc; k++) begin
            if (m_pend[k-1] && enable[k-1]) return k;
        end
        return 0;
    endfunction

    task automatic model_clear();
        m_pend = '0; m_act = '0; m_miss = '0; m_srcq = '0;
        m_irq = 1'b0; m_irq_id = '0; m_cv = 1'b0; m_cid = '0;
        exp_q.delete();
    endtask

    // Apply one clock edge's worth of events to the model, event by event
    task automatic model_edge();
        logic [NumSrc-1:0] p0, a0, s0, np, na, nm;
        int  win;
        bit  src, rise, done;
        p0 = m_pend; a0 = m_act; s0 = m_miss;
        np = p0; na = a0; nm = s0;
        win = lowest_id();
        for (int k = 1; k <= NumSrc; k++) begin
            src  = intr_src[k-1];
            rise = src && !m_srcq[k-1];
            done = complete && (int'(complete_id) == k) && a0[k-1];
            if (claim && win == k) begin
                np[k-1] = 1'b0;
                na[k-1] = 1'b1;
            end
            if (done) begin
                na[k-1] = 1'b0;
                if (s0[k-1]) begin
                    np[k-1] = 1'b1;
                    nm[k-1] = 1'b0;
                end
            end
            if (edge_mode[k-1]) begin
                if (rise) begin
                    if (!p0[k-1] && !a0[k-1]) np[k-1] = 1'b1;
                    else if (!(done && s0[k-1])) nm[k-1] = 1'b1;
                end
            end else if (src && !p0[k-1] && !a0[k-1]) begin
                np[k-1] = 1'b1;
            end
            if (s0[k-1] && !p0[k-1] && !a0[k-1]) begin
                np[k-1] = 1'b1;
                nm[k-1] = 1'b0;
            end
        end
        m_irq    = (win != 0);
        m_irq_id = IdWidth'(win);
        m_cv     = claim;
        if (claim) begin
            m_cid = IdWidth'(win);
            exp_q.push_back(IdWidth'(win));
        end
        m_pend = np; m_act = na; m_miss = nm;
        m_srcq = intr_src;
    endtask

    task automatic compare_all();
        check("pending", pending_o, m_pend);
        check("active", active_o, m_act);
        check("irq", irq_o, m_irq);
        check("irq_id", irq_id_o, m_irq_id);
        check("claim_valid", claim_valid_o, m_cv);
        check("claim_id_held", claim_id_o, m_cid);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_claim();
        claim = 1'b1;
        step();
        claim = 1'b0;
    endtask

    task automatic do_complete(input int id);
        complete = 1'b1;
        complete_id = IdWidth'(id);
        step();
        complete = 1'b0;
        complete_id = '0;
    endtask

    // Monitor: pop the expected claim result whenever the DUT presents one
    always @(negedge clk) begin
        if (!rst && claim_valid_o) begin
            if (exp_q.size() == 0) begin
                check("claim_unexpected", claim_valid_o, 1'b0);
            end else begin
                check("claim_scoreboard", claim_id_o, exp_q.pop_front());
            end
        end
    end

    // Watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        model_clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq", irq_o, 0);
        check("rst_irq_id", irq_id_o, 0);
        check("rst_claim_valid", claim_valid_o, 0);
        check("rst_claim_id", claim_id_o, 0);
        check("rst_pending", pending_o, 0);
        check("rst_active", active_o, 0);
        #2 rst = 1'b0;

        // Level source 3
        intr_src[2] = 1'b1;
        step();
        step();
        check("t1_irq", irq_o, 1);
        check("t1_irq_id", irq_id_o, 3);
        do_claim();
        check("t1_claim_id", claim_id_o, 3);
        check("t1_active", active_o[2], 1);
        check("t1_pending", pending_o[2], 0);
        do_complete(3);
        step();
        check("t1_repend", pending_o[2], 1);
        intr_src[2] = 1'b0;
        do_claim();
        do_complete(3);
        step();

        // Sources 5 and 17 together
        intr_src[4] = 1'b1; intr_src[16] = 1'b1;
        step();
        intr_src[4] = 1'b0; intr_src[16] = 1'b0;
        step();
        check("t2_irq_id", irq_id_o, 5);
        do_claim();
        check("t2_claim5", claim_id_o, 5);
        do_claim();
        check("t2_claim17", claim_id_o, 17);
        do_claim();
        check("t2_claim_none_valid", claim_valid_o, 1);
        check("t2_claim_none_id", claim_id_o, 0);
        do_complete(5);
        do_complete(17);
        step();

        // Edge source 10 with missed edges
        edge_mode[9] = 1'b1;
        intr_src[9] = 1'b1; step();
        intr_src[9] = 1'b0; step();
        do_claim();
        check("t3_claim10", claim_id_o, 10);
        for (int p = 0; p < 2; p++) begin
            intr_src[9] = 1'b1; step();
            intr_src[9] = 1'b0; step();
        end
        check("t3_not_pending", pending_o[9], 0);
        do_complete(10);
        check("t3_repend", pending_o[9], 1);
        step();
        check("t3_irq_id", irq_id_o, 10);
        do_claim();
        do_complete(10);
        step();
        check("t3_merged", pending_o[9], 0);

        // Disabled source 8, enabled later
        enable[7] = 1'b0;
        intr_src[7] = 1'b1; step();
        intr_src[7] = 1'b0; step();
        step();
        check("t4_irq_off", irq_o, 0);
        check("t4_latched", pending_o[7], 1);
        repeat (17) step();
        enable[7] = 1'b1;
        step();
        check("t4_irq_on", irq_o, 1);
        check("t4_irq_id", irq_id_o, 8);
        do_claim();
        do_complete(8);

        // Invalid completes
        intr_src[1] = 1'b1; step();
        intr_src[1] = 1'b0; step();
        do_claim();
        do_complete(0);
        check("t5_id0", active_o, 46'h2);
        do_complete(47);
        check("t5_id47", active_o, 46'h2);
        do_complete(4);
        check("t5_inactive", active_o, 46'h2);
        do_complete(2);
        check("t5_valid", active_o, 0);

        // Reset mid-operation
        intr_src[0] = 1'b1; intr_src[45] = 1'b1; step();
        intr_src[0] = 1'b0; intr_src[45] = 1'b0; step();
        do_claim();
        #1 rst = 1'b1;
        #1;
        check("t6_irq", irq_o, 0);
        check("t6_irq_id", irq_id_o, 0);
        check("t6_claim_valid", claim_valid_o, 0);
        check("t6_claim_id", claim_id_o, 0);
        check("t6_pending", pending_o, 0);
        check("t6_active", active_o, 0);
        model_clear();
        intr_src = '0;
        edge_mode[0] = 1'b1;
        intr_src[0] = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();
        check("t6_edge_pend", pending_o[0], 1);
        do_claim();
        do_complete(1);
        step();
        step();
        check("t6_once", pending_o[0], 0);
        intr_src[0] = 1'b0;
        step();

        // Randomized traffic against the model
        edge_mode = {$urandom(), $urandom()};
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NumSrc; b++) begin
                if ($urandom_range(0, 15) == 0) intr_src[b] = ~intr_src[b];
            end
            if ($urandom_range(0, 31) == 0) edge_mode[$urandom_range(0, NumSrc-1)] ^= 1'b1;
            if ($urandom_range(0, 31) == 0) enable[$urandom_range(0, NumSrc-1)] ^= 1'b1;
            claim = ($urandom_range(0, 3) == 0);
            complete = ($urandom_range(0, 2) == 0);
            complete_id = IdWidth'($urandom_range(0, 63));
            if (complete && $urandom_range(0, 9) < 7 && m_act != '0) begin
                int ids[$];
                for (int k = 1; k <= NumSrc; k++) if (m_act[k-1]) ids.push_back(k);
                complete_id = IdWidth'(ids[$urandom_range(0, ids.size() - 1)]);
            end
            step();
        end
        claim = 1'b0;
        complete = 1'b0;
        step();
        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/top_chip_intr_aggregator.md
Name: top_chip_intr_aggregator

Overview:
- Parametrised interrupt gateway and aggregator for the system bus.
- Concatenates the AON timer, I2C, SPI host, UART and USBDEV interrupt vectors (46 lines by default) into one core-facing request.
- Each source can be set to level or edge mode, and each has an enable bit.
- Fixed-priority arbitration with a claim/complete handshake. An edge that arrives while its source is in service is remembered and re-raised later, not lost.

Parameters:
- NumSrc, 46, number of interrupt sources. Source IDs are 1..NumSrc; ID 0 means "none".
- IdWidth, 6, width of ID fields. Must be >= $clog2(NumSrc+1); elaboration assertion fails otherwise.

Ports:
- clk_i  in  1  system clock (SysClkFreq domain)
- rst_i  in  1  asynchronous active-high reset
- intr_src_i  in  NumSrc  raw interrupt lines, already synchronous to clk_i; bit k-1 is ID k
- edge_mode_i  in  NumSrc  per source: 1 = rising-edge triggered, 0 = level triggered
- enable_i  in  NumSrc  per-source enable
- claim_i  in  1  single-cycle claim request
- complete_i  in  1  single-cycle completion strobe
- complete_id_i  in  IdWidth  ID being completed
- irq_o  out  1  registered: any enabled pending source
- irq_id_o  out  IdWidth  registered: highest-priority enabled pending ID, 0 if none
- claim_valid_o  out  1  one-cycle pulse, cycle after claim_i
- claim_id_o  out  IdWidth  claimed ID (0 if nothing was claimable); held until next claim
- pending_o  out  NumSrc  pending state
- active_o  out  NumSrc  in-service state

Behaviour:
- Reset (async assert, sync to clk_i on release):
  - pending, active, missed, src_q, irq_o, irq_id_o, claim_valid_o and claim_id_o all go to 0.
  - src_q resets to 0, so an edge-mode source already high on the first cycle out of reset registers as an edge.
- Per-source state: pending, active and missed flops; src_q holds the previous-cycle intr_src_i.
- Level mode:
  - pending sets when src=1 && !pending && !active.
  - Once set, pending stays set until claimed, even if src drops.
- Edge mode:
  - A rising edge (src && !src_q) sets pending if !pending && !active.
  - A rising edge while pending or active sets missed instead.
  - Further edges while missed is set are merged into it.
- Arbitration: combinational over pending & enable; the lowest ID wins.
  - irq_o and irq_id_o are registered from this result, giving one cycle latency from pending to irq_o.
- Disabled sources still latch pending but are never signalled or claimed. Enabling one later raises irq_o one cycle after the enable.
- Claim (claim_i=1 in cycle N):
  - Winner W is computed from pending & enable in cycle N.
  - In cycle N+1: claim_valid_o=1, claim_id_o=W, pending[W]=0, active[W]=1.
  - If W=0, nothing changes except claim_valid_o=1 and claim_id_o=0.
  - claim_i held high for several cycles is treated as back-to-back claims, each one using the state updated by the previous claim.
- Complete (complete_i=1 in cycle N, ID=k):
  - Accepted only if 1<=k<=NumSrc and active[k]=1; otherwise ignored with no state change.
  - On acceptance, in cycle N+1: active[k]=0.
  - Also in N+1, if missed[k]=1: pending[k]=1 and missed[k]=0.
  - A level source still asserted re-pends in N+2, through the normal gateway rule.
- Simultaneous events:
  - Claim and complete in the same cycle are processed independently. They cannot target the same source, because a claimed source must be pending and therefore not active.
  - A new edge on a source in the same cycle it is claimed goes to missed; the claim still takes the source.
  - A new edge in the same cycle as a complete for that source also goes to missed, so it re-pends on the following cycle.
- edge_mode_i changes affect only future gateway decisions; existing pending, active and missed state is kept.
- No combinational path from any input to any output.

Test Plan:
- Level source ID 3 held high, enable=all:
  - irq_o=1 and irq_id_o=3 two cycles after the rise.
  - claim -> claim_id_o=3, active_o[2]=1, pending_o[2]=0.
  - complete(3) with the source still high -> pending_o[2]=1 again two cycles later.
- Sources 5 and 17 pending together:
  - irq_id_o=5.
  - claim -> 5; next claim -> 17; a third claim -> claim_valid_o=1, claim_id_o=0.
- Edge source ID 10:
  - Pulse, claim, then two more pulses while active -> pending_o[9]=0, missed set.
  - complete(10) -> pending_o[9]=1 next cycle; irq_id_o=10 the cycle after.
- Disabled source 8 pulses; enable_i[7] is set 20 cycles later -> irq_o rises exactly one cycle after the enable.
- Invalid completes are ignored with no state change:
  - complete_id_i=0.
  - complete_id_i=47.
  - complete_id_i naming a non-active ID.
- Reset mid-operation:
  - With sources 1 and 46 active/pending, assert rst_i asynchronously -> all outputs are 0 in the same cycle.
  - After release, an edge source held high pends once.
